// File: rtl/fft16_twiddle_sequencer.sv
// Walks the 4 radix-2 DIT stages x 8 butterflies of a 16-point FFT and streams
// the selected (optionally conjugated) twiddle plus data addresses downstream.
module fft16_twiddle_sequencer #(
  parameter int unsigned N    = 16,
  parameter bit          CONJ = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [8*N-1:0] tw_re_bus,
  input  logic [8*N-1:0] tw_im_bus,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [N-1:0]   tw_re,
  output logic [N-1:0]   tw_im,
  output logic [3:0]     addr_top,
  output logic [3:0]     addr_bot,
  output logic [1:0]     stage,
  output logic           last,
  output logic           busy,
  output logic           done
);

  localparam int unsigned NSLOT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [1:0]     stage_q;
  logic [2:0]     bfly_q;
  logic           valid_q;
  logic [N-1:0]   re_q;
  logic [N-1:0]   im_q;
  logic [3:0]     top_q;
  logic [3:0]     bot_q;
  logic           last_q;
  logic           busy_q;
  logic           done_q;

  logic           xfer;
  logic [1:0]     stage_d;
  logic [2:0]     bfly_d;
  logic [2:0]     k_d;
  logic [3:0]     top_d;
  logic [3:0]     bot_d;
  logic [N-1:0]   sel_re;
  logic [N-1:0]   sel_im;
  logic [N-1:0]   re_d;
  logic [N-1:0]   im_d;

  assign xfer = valid_q & out_ready;

  // Index of the item to load next: (0,0) from IDLE, otherwise the successor.
  always_comb begin
    stage_d = 2'd0;
    bfly_d  = 3'd0;
    if (state_q != ST_IDLE) begin
      bfly_d  = bfly_q + 3'd1;
      stage_d = (bfly_q == 3'd7) ? stage_q + 2'd1 : stage_q;
    end
  end

  // Butterfly geometry: p is the low s bits of b, the group index sits above it.
  always_comb begin
    k_d   = 3'd0;
    top_d = 4'd0;
    case (stage_d)
      2'd0: begin
        k_d   = 3'd0;
        top_d = {bfly_d, 1'b0};
      end
      2'd1: begin
        k_d   = {bfly_d[0], 2'b00};
        top_d = {bfly_d[2:1], 1'b0, bfly_d[0]};
      end
      2'd2: begin
        k_d   = {bfly_d[1:0], 1'b0};
        top_d = {bfly_d[2], 1'b0, bfly_d[1:0]};
      end
      default: begin
        k_d   = bfly_d;
        top_d = {1'b0, bfly_d};
      end
    endcase
    bot_d = top_d + (4'd1 << stage_d);
  end

  always_comb begin
    sel_re = '0;
    sel_im = '0;
    for (int i = 0; i < int'(NSLOT); i++) begin
      if (3'(i) == k_d) begin
        sel_re = tw_re_bus[i*N +: N];
        sel_im = tw_im_bus[i*N +: N];
      end
    end
    re_d = sel_re;
    im_d = CONJ ? ({N{1'b0}} - sel_im) : sel_im;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= 2'd0;
      bfly_q  <= 3'd0;
      valid_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      top_q   <= 4'd0;
      bot_q   <= 4'd0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            re_q    <= re_d;
            im_q    <= im_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            last_q  <= (bfly_d == 3'd7);
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if (last_q && (stage_q == 2'd3)) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              stage_q <= stage_d;
              bfly_q  <= bfly_d;
              re_q    <= re_d;
              im_q    <= im_d;
              top_q   <= top_d;
              bot_q   <= bot_d;
              last_q  <= (bfly_d == 3'd7);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          stage_q <= 2'd0;
          bfly_q  <= 3'd0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign tw_re     = re_q;
  assign tw_im     = im_q;
  assign addr_top  = top_q;
  assign addr_bot  = bot_q;
  assign stage     = stage_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fft16_twiddle_sequencer.sv
// Scoreboard bench: stimulus pushes the expected 32-item stream per start,
// a negedge monitor pops and compares on every transfer (CONJ=1 and CONJ=0 DUTs).
module tb_fft16_twiddle_sequencer;

  localparam int unsigned N = 16;

  typedef struct packed {
    logic [1:0]   s;
    logic [2:0]   b;
    logic [N-1:0] re;
    logic [N-1:0] imc;
    logic [N-1:0] imp;
    logic [3:0]   top;
    logic [3:0]   bot;
    logic         last;
  } item_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic           out_ready;
  logic [8*N-1:0] re_bus;
  logic [8*N-1:0] im_bus;

  logic           out_valid0, last0, busy0, done0;
  logic [N-1:0]   tw_re0, tw_im0;
  logic [3:0]     addr_top0, addr_bot0;
  logic [1:0]     stage0;
  logic           out_valid1, last1, busy1, done1;
  logic [N-1:0]   tw_re1, tw_im1;
  logic [3:0]     addr_top1, addr_bot1;
  logic [1:0]     stage1;

  fft16_twiddle_sequencer #(.N(N), .CONJ(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .tw_re_bus(re_bus), .tw_im_bus(im_bus),
    .out_ready(out_ready), .out_valid(out_valid0), .tw_re(tw_re0), .tw_im(tw_im0),
    .addr_top(addr_top0), .addr_bot(addr_bot0), .stage(stage0), .last(last0),
    .busy(busy0), .done(done0)
  );

  fft16_twiddle_sequencer #(.N(N), .CONJ(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .tw_re_bus(re_bus), .tw_im_bus(im_bus),
    .out_ready(out_ready), .out_valid(out_valid1), .tw_re(tw_re1), .tw_im(tw_im1),
    .addr_top(addr_top1), .addr_bot(addr_bot1), .stage(stage1), .last(last1),
    .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total = 0;
  int          bad = 0;
  int          spot_mode = 0;
  item_t       q[$];
  logic [N-1:0] tbl_re [8];
  logic [N-1:0] tbl_im [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] snap();
    return {2'b00, out_valid0, tw_re0, tw_im0, addr_top0, addr_bot0, stage0,
            last0, busy0, done0, tw_im1};
  endfunction

  task automatic load_rom();
    logic [N-1:0] r [8] = '{16'h0100, 16'h00ED, 16'h00B5, 16'h0062,
                            16'h0000, 16'hFF9E, 16'hFF4B, 16'hFF13};
    logic [N-1:0] m [8] = '{16'h0000, 16'h0062, 16'h00B5, 16'h00ED,
                            16'h0100, 16'h00ED, 16'h00B5, 16'h0062};
    for (int k = 0; k < 8; k++) begin
      tbl_re[k] = r[k];
      tbl_im[k] = m[k];
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < 8; k++) begin
      tbl_re[k] = N'($urandom);
      tbl_im[k] = N'($urandom);
    end
  endtask

  task automatic put_table();
    for (int k = 0; k < 8; k++) begin
      re_bus[k*N +: N] = tbl_re[k];
      im_bus[k*N +: N] = tbl_im[k];
    end
  endtask

  // Reference stream for one sequence, from the index arithmetic of the DIT walk.
  task automatic push_seq();
    item_t e;
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 8; b++) begin
        int p, k, top;
        p     = b % (2 ** s);
        k     = p * (2 ** (3 - s));
        top   = (b / (2 ** s)) * (2 ** (s + 1)) + p;
        e.s   = 2'(s);
        e.b   = 3'(b);
        e.re  = tbl_re[k];
        e.imp = tbl_im[k];
        e.imc = ~tbl_im[k] + 16'd1;
        e.top = 4'(top);
        e.bot = 4'(top + 2 ** s);
        e.last = (b == 7);
        q.push_back(e);
      end
    end
  endtask

  // Drive one cycle; while stalled the twiddle buses carry garbage to expose any leakage.
  task automatic drive_cycle(input logic st, input logic rdy);
    @(posedge clk);
    #1;
    start     = st;
    out_ready = rdy;
    if (st || rdy) put_table();
    else begin
      re_bus = {$urandom, $urandom, $urandom, $urandom};
      im_bus = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic wait_done(input bit extra_starts);
    bit got_done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      drive_cycle(extra_starts ? ($urandom_range(0, 3) == 0) : 1'b0, 1'($urandom));
      if (done0) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(got_done), 64'd1);
    chk("all_32_transferred", 64'(q.size()), 64'd0);
    drive_cycle(1'b0, 1'($urandom));
    drive_cycle(1'b0, 1'($urandom));
    chk("no_restart", 64'({out_valid0, busy0}), 64'd0);
  endtask

  task automatic run_seq(input bit extra_starts);
    drive_cycle(1'b1, 1'($urandom));
    push_seq();
    wait_done(extra_starts);
  endtask

  // Monitor: transfers pop the scoreboard; stalls must hold every output bit-stable.
  item_t       me;
  logic        exp_done = 1'b0;
  logic        have_prev = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_snap = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_done  = 1'b0;
      have_prev = 1'b0;
    end else begin
      chk("done0", 64'(done0), 64'(exp_done));
      chk("done1", 64'(done1), 64'(exp_done));
      exp_done = 1'b0;
      if (have_prev && prev_stall) chk("stall_hold", snap(), prev_snap);
      if (out_valid0) begin
        if (q.size() == 0) begin
          chk("extra_item", 64'(out_valid0), 64'd0);
        end else begin
          me = q[0];
          chk("stage_last", 64'({stage0, last0, busy0}), 64'({me.s, me.last, 1'b1}));
          chk("addr", 64'({addr_top0, addr_bot0}), 64'({me.top, me.bot}));
          chk("tw_conj", 64'({tw_re0, tw_im0}), 64'({me.re, me.imc}));
          chk("dut_noconj",
              64'({out_valid1, tw_re1, tw_im1, addr_top1, addr_bot1, stage1, last1}),
              64'({1'b1, me.re, me.imp, me.top, me.bot, me.s, me.last}));
          if (spot_mode == 1) begin
            if (me.s == 2'd0 && me.b == 3'd6)
              chk("spot_0_6", 64'({addr_top0, addr_bot0, tw_re0, tw_im0}),
                  {24'd0, 4'd12, 4'd13, 16'h0100, 16'h0000});
            if (me.s == 2'd1 && me.b == 3'd3)
              chk("spot_1_3", 64'({addr_top0, addr_bot0, tw_re0, tw_im0}),
                  {24'd0, 4'd5, 4'd7, 16'h0000, 16'hFF00});
            if (me.s == 2'd2 && me.b == 3'd5)
              chk("spot_2_5", 64'({addr_top0, addr_bot0, tw_re0, tw_im0}),
                  {24'd0, 4'd9, 4'd13, 16'h00B5, 16'hFF4B});
            if (me.s == 2'd3 && me.b == 3'd5)
              chk("spot_3_5", 64'({addr_top0, addr_bot0, tw_re0, tw_im0, last0}),
                  {23'd0, 4'd5, 4'd13, 16'hFF9E, 16'hFF13, 1'b0});
            if (me.s == 2'd3 && me.b == 3'd7)
              chk("spot_noconj_3_7", 64'({addr_top1, addr_bot1, tw_re1, tw_im1, last1}),
                  {23'd0, 4'd7, 4'd15, 16'hFF13, 16'h0062, 1'b1});
          end
          if (spot_mode == 2 && me.s == 2'd3 && me.b == 3'd1)
            chk("wrap_3_1", 64'(tw_im0), 64'h8000);
          if (out_ready) begin
            void'(q.pop_front());
            if (me.s == 2'd3 && me.last) exp_done = 1'b1;
          end
        end
      end
      have_prev  = 1'b1;
      prev_stall = out_valid0 && !out_ready;
      prev_snap  = snap();
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    re_bus    = '0;
    im_bus    = '0;
    load_rom();
    #2;
    chk("reset_outs0", snap(), 64'd0);
    chk("reset_outs1", 64'({out_valid1, tw_re1, addr_top1, addr_bot1, stage1, last1, busy1, done1}), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 put_table();
    repeat (3) drive_cycle(1'b0, 1'($urandom));
    chk("idle_no_valid", 64'({out_valid0, busy0}), 64'd0);

    // Cycle-accurate full run with out_ready held; starts in cycles 32..34.
    spot_mode = 1;
    drive_cycle(1'b1, 1'b1);
    push_seq();
    for (int c = 1; c <= 34; c++) begin
      drive_cycle(c >= 32, 1'b1);
      chk($sformatf("t_valid_c%0d", c), 64'(out_valid0), 64'(c <= 32));
      chk($sformatf("t_busy_c%0d", c), 64'(busy0), 64'(c <= 33));
      chk($sformatf("t_done_c%0d", c), 64'(done0), 64'(c == 33));
    end
    push_seq();
    drive_cycle(1'b0, 1'($urandom));
    chk("restart_valid_c35", 64'({out_valid0, busy0}), 64'd3);
    wait_done(1'b1);

    // Random twiddle tables under random backpressure and ignored starts.
    spot_mode = 0;
    for (int r = 0; r < 3; r++) begin
      load_random();
      run_seq(1'b1);
    end

    // Negating 0x8000 must wrap to itself.
    load_rom();
    tbl_im[1] = 16'h8000;
    spot_mode = 2;
    run_seq(1'b0);

    // Reset while stalled on item (2,3).
    load_rom();
    spot_mode = 1;
    drive_cycle(1'b1, 1'b1);
    push_seq();
    for (int c = 1; c <= 19; c++) drive_cycle(1'b0, 1'b1);
    for (int c = 20; c <= 22; c++) drive_cycle(1'b0, 1'b0);
    chk("stall_item_2_3", 64'({out_valid0, stage0, addr_top0, addr_bot0}),
        64'({1'b1, 2'd2, 4'd3, 4'd7}));
    @(posedge clk);
    #2 rst = 1'b1;
    q.delete();
    re_bus = '0;
    im_bus = '0;
    #1;
    chk("midrun_reset0", snap(), 64'd0);
    chk("midrun_reset1", 64'({out_valid1, tw_re1, addr_top1, addr_bot1, stage1, last1, busy1, done1}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 put_table();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, 1'($urandom));
      chk("post_reset_idle", 64'({out_valid0, busy0, done0}), 64'd0);
    end

    run_seq(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
